// File: rtl/msg_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one outbound 4-phase req/ack message channel.
// The winner's {addr,data} message is latched and forwarded; completed messages are counted.
module msg_rr_arbiter #(
  parameter int unsigned ASZ = 4,
  parameter int unsigned DSZ = 8,
  localparam int unsigned MSZ = ASZ + DSZ
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic           rcv0_req,
  input  logic [MSZ-1:0] rcv0_data,
  output logic           rcv0_ack,
  input  logic           rcv1_req,
  input  logic [MSZ-1:0] rcv1_data,
  output logic           rcv1_ack,
  output logic           snd0_req,
  output logic [MSZ-1:0] snd0_data,
  input  logic           snd0_ack,
  output logic           busy,
  output logic [7:0]     sent_cnt
);

  typedef enum logic [1:0] {StInit, StIdle, StSend, StDrain} state_e;

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           sreq_q, sreq_d;
  logic [MSZ-1:0] sdata_q, sdata_d;
  logic           busy_q, busy_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           last_q, last_d;

  logic elig0, elig1;
  logic pick1;

  // A requester whose ack is still high has already been captured.
  assign elig0 = rcv0_req & ~ack0_q;
  assign elig1 = rcv1_req & ~ack1_q;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    sreq_d  = sreq_q;
    sdata_d = sdata_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pick1   = 1'b0;

    if (ack0_q && !rcv0_req) ack0_d = 1'b0;
    if (ack1_q && !rcv1_req) ack1_d = 1'b0;

    unique case (state_q)
      StInit: begin
        ready_d = 1'b1;
        state_d = StIdle;
      end
      StIdle: begin
        if (elig0 || elig1) begin
          // On a tie, the requester not served last time wins.
          pick1   = elig1 && (!elig0 || !last_q);
          sdata_d = pick1 ? rcv1_data : rcv0_data;
          if (pick1) ack1_d = 1'b1;
          else       ack0_d = 1'b1;
          last_d  = pick1;
          sreq_d  = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (snd0_ack) begin
          sreq_d  = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!snd0_ack) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase

    busy_d = (state_d == StSend) || (state_d == StDrain);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= StInit;
      ready_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      sreq_q  <= 1'b0;
      sdata_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      sreq_q  <= sreq_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign ready     = ready_q;
  assign rcv0_ack  = ack0_q;
  assign rcv1_ack  = ack1_q;
  assign snd0_req  = sreq_q;
  assign snd0_data = sdata_q;
  assign busy      = busy_q;
  assign sent_cnt  = cnt_q;

endmodule

// File: tb/tb_msg_rr_arbiter.sv
// Self-checking bench for msg_rr_arbiter: cycle-level producer/consumer models with tagged
// random messages, checked against per-requester queues and a round-robin winner model.
module tb_msg_rr_arbiter;
  localparam int unsigned ASZ = 4;
  localparam int unsigned DSZ = 8;
  localparam int unsigned MSZ = ASZ + DSZ;

  logic           i_clk = 1'b0;
  logic           reset;
  logic           ready;
  logic           rcv0_req, rcv1_req;
  logic [MSZ-1:0] rcv0_data, rcv1_data;
  logic           rcv0_ack, rcv1_ack;
  logic           snd0_req;
  logic [MSZ-1:0] snd0_data;
  logic           snd0_ack;
  logic           busy;
  logic [7:0]     sent_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  bit exp_last = 1'b1;
  logic [MSZ-1:0] q0[$];
  logic [MSZ-1:0] q1[$];

  always #5 i_clk = ~i_clk;

  msg_rr_arbiter #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .ready     (ready),
    .rcv0_req  (rcv0_req),
    .rcv0_data (rcv0_data),
    .rcv0_ack  (rcv0_ack),
    .rcv1_req  (rcv1_req),
    .rcv1_data (rcv1_data),
    .rcv1_ack  (rcv1_ack),
    .snd0_req  (snd0_req),
    .snd0_data (snd0_data),
    .snd0_ack  (snd0_ack),
    .busy      (busy),
    .sent_cnt  (sent_cnt)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({ready, rcv0_ack, rcv1_ack, snd0_req, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {ready, rcv0_ack, rcv1_ack, snd0_req, busy});
    end
    n_checks++;
    if (snd0_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", snd0_data);
    end
    n_checks++;
    if (sent_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d expected 0", sent_cnt);
    end
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_first: got %b expected 0", ready);
    end
    tick();
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_next: got %b expected 1", ready);
    end
    exp_cnt  = 0;
    exp_last = 1'b1;
  endtask

  task automatic test_single();
    rcv0_data = 12'h2A5;
    rcv0_req  = 1'b1;
    tick();
    n_checks++;
    if ({rcv0_ack, snd0_req, busy} !== 3'b111) begin
      n_fail++; $display("FAIL single_grant: got %b expected 111", {rcv0_ack, snd0_req, busy});
    end
    n_checks++;
    if (snd0_data !== 12'h2A5) begin
      n_fail++; $display("FAIL single_data: got %h expected 2a5", snd0_data);
    end
    snd0_ack = 1'b1;
    tick();
    n_checks++;
    if (snd0_req !== 1'b0) begin
      n_fail++; $display("FAIL single_req_fall: got %b expected 0", snd0_req);
    end
    snd0_ack = 1'b0;
    rcv0_req = 1'b0;
    tick();
    exp_cnt  = exp_cnt + 1;
    exp_last = 1'b0;
    n_checks++;
    if ({rcv0_ack, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_release: got %b expected 00", {rcv0_ack, busy});
    end
    n_checks++;
    if (sent_cnt !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL single_cnt: got %0d expected %0d", sent_cnt, exp_cnt);
    end
  endtask

  task automatic test_idle_ack();
    snd0_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({snd0_req, busy} !== 2'b00 || sent_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL idle_ack: got req/busy %b cnt %0d expected 00 cnt %0d",
                 {snd0_req, busy}, sent_cnt, exp_cnt);
      end
    end
    snd0_ack = 1'b0;
    tick();
  endtask

  // Cycle-level producers (drop req on ack, re-request after a random gap) and consumer
  // (ack after a random delay). Message MSB tags the source requester.
  task automatic run_traffic(input int n0, input int n1, input int max_gap, input int max_cons,
                             input bit check_alt);
    int rem[2];
    int gap[2];
    int delivered = 0;
    int cycles    = 0;
    int budget;
    int cwait     = 0;
    bit in_xfer   = 1'b0;
    bit exp_id;
    bit id;
    logic [MSZ-1:0] held = '0;
    logic [MSZ-1:0] exp_data;
    logic [MSZ-2:0] r;
    rem[0] = n0; rem[1] = n1;
    gap[0] = 0;  gap[1] = 0;
    budget = (n0 + n1) * (2 * max_gap + max_cons + 12) + 50;
    exp_id = ~exp_last;
    while (delivered < n0 + n1 && cycles < budget) begin
      tick();
      cycles++;
      if (rcv0_req && rcv0_ack) begin
        rcv0_req = 1'b0; gap[0] = int'($urandom_range(max_gap, 0));
      end else if (!rcv0_req && !rcv0_ack && rem[0] > 0) begin
        if (gap[0] > 0) gap[0]--;
        else begin
          r = (MSZ-1)'($urandom); rcv0_data = {1'b0, r};
          q0.push_back(rcv0_data); rcv0_req = 1'b1; rem[0]--;
        end
      end
      if (rcv1_req && rcv1_ack) begin
        rcv1_req = 1'b0; gap[1] = int'($urandom_range(max_gap, 0));
      end else if (!rcv1_req && !rcv1_ack && rem[1] > 0) begin
        if (gap[1] > 0) gap[1]--;
        else begin
          r = (MSZ-1)'($urandom); rcv1_data = {1'b1, r};
          q1.push_back(rcv1_data); rcv1_req = 1'b1; rem[1]--;
        end
      end
      if (snd0_req && !snd0_ack) begin
        if (!in_xfer) begin
          in_xfer = 1'b1;
          held    = snd0_data;
          cwait   = int'($urandom_range(max_cons, 0));
          id      = snd0_data[MSZ-1];
          n_checks++;
          if ((id == 1'b0 && q0.size() == 0) || (id == 1'b1 && q1.size() == 0)) begin
            n_fail++; $display("FAIL xfer_source: got msg %h expected one pending", snd0_data);
          end else begin
            exp_data = (id == 1'b0) ? q0.pop_front() : q1.pop_front();
            if (snd0_data !== exp_data) begin
              n_fail++; $display("FAIL xfer_data: got %h expected %h", snd0_data, exp_data);
            end
          end
          if (check_alt) begin
            n_checks++;
            if (id !== exp_id) begin
              n_fail++; $display("FAIL alternation: got rcv%0d expected rcv%0d", id, exp_id);
            end
            exp_last = exp_id;
            exp_id   = ~exp_id;
          end else begin
            exp_last = id;
          end
        end else begin
          n_checks++;
          if (snd0_data !== held) begin
            n_fail++; $display("FAIL xfer_stable: got %h expected %h", snd0_data, held);
          end
        end
        if (cwait == 0) snd0_ack = 1'b1;
        else cwait--;
      end else if (!snd0_req && snd0_ack) begin
        snd0_ack  = 1'b0;
        in_xfer   = 1'b0;
        delivered++;
        exp_cnt   = (exp_cnt + 1) % 256;
      end
    end
    n_checks++;
    if (delivered != n0 + n1) begin
      n_fail++; $display("FAIL traffic_timeout: got %0d msgs expected %0d", delivered, n0 + n1);
    end
    tick();
    tick();
    n_checks++;
    if (sent_cnt !== 8'(exp_cnt) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL traffic_end: got cnt %0d busy %b expected cnt %0d busy 0",
               sent_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_alternation();
    run_traffic(4, 4, 0, 3, 1'b1);
  endtask

  task automatic test_stall();
    logic [MSZ-1:0] d0, d1;
    d0 = {1'b0, 11'h3C1};
    d1 = {1'b1, 11'h11E};
    rcv0_data = d0;
    rcv0_req  = 1'b1;
    tick();
    n_checks++;
    if ({rcv0_ack, snd0_req} !== 2'b11) begin
      n_fail++; $display("FAIL stall_grant: got %b expected 11", {rcv0_ack, snd0_req});
    end
    rcv0_req  = 1'b0;
    rcv1_data = d1;
    rcv1_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({snd0_req, busy, rcv1_ack} !== 3'b110 || snd0_data !== d0) begin
        n_fail++;
        $display("FAIL stall_hold: got req/busy/ack1 %b data %h expected 110 data %h",
                 {snd0_req, busy, rcv1_ack}, snd0_data, d0);
      end
    end
    snd0_ack = 1'b1;
    tick();
    snd0_ack = 1'b0;
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
    tick();
    n_checks++;
    if (rcv1_ack !== 1'b1 || snd0_data !== d1) begin
      n_fail++;
      $display("FAIL stall_next: got ack1 %b data %h expected 1 %h", rcv1_ack, snd0_data, d1);
    end
    snd0_ack = 1'b1;
    rcv1_req = 1'b0;
    tick();
    snd0_ack = 1'b0;
    tick();
    exp_cnt  = (exp_cnt + 1) % 256;
    exp_last = 1'b1;
    n_checks++;
    if (sent_cnt !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", sent_cnt, exp_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      run_traffic(int'($urandom_range(20, 10)), int'($urandom_range(20, 10)), 4, 4, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    rcv1_data = {1'b1, 11'h7A5};
    rcv1_req  = 1'b1;
    tick();
    n_checks++;
    if ({snd0_req, busy} !== 2'b11) begin
      n_fail++; $display("FAIL mid_pre: got %b expected 11", {snd0_req, busy});
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({snd0_req, rcv0_ack, rcv1_ack, ready, busy} !== 5'b0 || sent_cnt !== 8'd0 ||
        snd0_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got flags %b cnt %0d data %h expected 00000 0 0",
               {snd0_req, rcv0_ack, rcv1_ack, ready, busy}, sent_cnt, snd0_data);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({ready, rcv1_ack} !== 2'b10) begin
      n_fail++; $display("FAIL init_ignore: got %b expected 10", {ready, rcv1_ack});
    end
    tick();
    n_checks++;
    if (rcv1_ack !== 1'b1 || snd0_data !== {1'b1, 11'h7A5}) begin
      n_fail++; $display("FAIL post_init_grant: got %b %h expected 1 fa5", rcv1_ack, snd0_data);
    end
    snd0_ack = 1'b1;
    rcv1_req = 1'b0;
    tick();
    snd0_ack = 1'b0;
    tick();
    exp_cnt  = 1;
    exp_last = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    n = 255 - exp_cnt;
    run_traffic(n / 2, n - n / 2, 1, 1, 1'b0);
    n_checks++;
    if (sent_cnt !== 8'd255) begin
      n_fail++; $display("FAIL wrap_255: got %0d expected 255", sent_cnt);
    end
    run_traffic(0, 1, 0, 0, 1'b0);
    n_checks++;
    if (sent_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_0: got %0d expected 0", sent_cnt);
    end
  endtask

  initial begin
    reset     = 1'b1;
    rcv0_req  = 1'b0;
    rcv1_req  = 1'b0;
    rcv0_data = '0;
    rcv1_data = '0;
    snd0_ack  = 1'b0;
    test_reset();
    test_single();
    test_idle_ack();
    test_alternation();
    test_stall();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
